// File: rtl/fix_pkg.sv
// FIX serialiser shared definitions.
//   - ASCII constants for the framing characters and the fixed header/trailer tags
//   - state_t: builder FSM states
//   - fld_t: one field-buffer entry (value bytes are held in a separate array so the
//     struct stays independent of the value width)
//   - bcd_digits(): number of significant decimal digits in a 5-digit BCD word
package fix_pkg;

  localparam logic [7:0]  CH_SOH           = 8'h01;
  localparam logic [7:0]  CH_EQ            = 8'h3d;
  localparam logic [7:0]  TAG_BEGIN_STRING = 8'h38;    // "8"
  localparam logic [7:0]  TAG_BODY_LENGTH  = 8'h39;    // "9"
  localparam logic [15:0] TAG_CHECKSUM     = 16'h3031; // "10", first char in LSB

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_LCONV,
    ST_HDR,
    ST_LEN,
    ST_BODY,
    ST_CCONV,
    ST_TRL
  } state_t;

  typedef struct packed {
    logic [31:0] tag;
    logic [2:0]  tag_len;
    logic [15:0] val_len;  // already clamped to VALUE_BYTES
    logic        vld;      // tag length 1..4; invalid entries occupy a slot but are never emitted
  } fld_t;

  // Leading-zero suppression: "0" still yields one digit.
  function automatic logic [2:0] bcd_digits(input logic [19:0] bcd);
    if (bcd[19:16] != 4'd0) return 3'd5;
    if (bcd[15:12] != 4'd0) return 3'd4;
    if (bcd[11:8]  != 4'd0) return 3'd3;
    if (bcd[7:4]   != 4'd0) return 3'd2;
    return 3'd1;
  endfunction

endpackage

// File: rtl/fix_bin2dec.sv
// Iterative double-dabble binary-to-BCD converter.
//   start_i : launch a conversion of bin_i (sampled only while idle)
//   bin_i   : 16-bit binary input
//   bcd_o   : 5 BCD digits, digit 0 in [3:0]; holds until the next start
//   done_o  : one-cycle pulse when bcd_o is final (16 cycles after start)
//   busy_o  : conversion in progress
module fix_bin2dec (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic [19:0] bcd_o,
  output logic        done_o,
  output logic        busy_o
);

  logic [15:0] shift_q, shift_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;

  // One shift-and-add-3 step pulling bit_in into the BCD register.
  function automatic logic [19:0] dabble(input logic [19:0] bcd, input logic bit_in);
    logic [19:0] adj;
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[18:0], bit_in};
  endfunction

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (!run_q) begin
      if (start_i) begin
        // The load cycle already performs the first of the 16 steps.
        bcd_d   = dabble(20'd0, bin_i[15]);
        shift_d = {bin_i[14:0], 1'b0};
        cnt_d   = 4'd15;
        run_d   = 1'b1;
      end
    end else begin
      bcd_d   = dabble(bcd_q, shift_q[15]);
      shift_d = {shift_q[14:0], 1'b0};
      cnt_d   = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;
  assign busy_o = run_q;

endmodule

// File: rtl/fix_msg_builder.sv
// Table-driven FIX message serialiser.
// Fields are written into a register buffer while IDLE; start_i builds
// 8=<BeginString>|9=<len>|<fields>|10=<csum>| over a byte stream.
//   fld_*         : field write port, fld_full_o / sticky fld_ovf_o status
//   start_i       : build a message (IDLE only); busy_o high until done_o
//   byte_*        : output stream. A byte transfers on byte_valid_o && byte_ready_i;
//                   while valid is high and ready is low, byte_o and byte_valid_o hold.
//   done_o        : one-cycle pulse after the final SOH transfer
//   dbg_state_o   : current FSM state, for observation only
module fix_msg_builder
  import fix_pkg::*;
#(
  parameter int          VALUE_BYTES = 32,
  parameter int          MAX_FIELDS  = 16,
  parameter logic [63:0] BEGIN_STR   = 64'h0034_2e34_2e58_4946,
  parameter int          BEGIN_LEN   = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fld_wr_i,
  input  logic [31:0]                      fld_tag_i,
  input  logic [2:0]                       fld_tag_len_i,
  input  logic [8*VALUE_BYTES-1:0]         fld_val_i,
  input  logic [$clog2(VALUE_BYTES+1)-1:0] fld_val_len_i,
  output logic                             fld_full_o,
  output logic                             fld_ovf_o,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic [7:0]                       byte_o,
  output logic                             byte_valid_o,
  input  logic                             byte_ready_i,
  output logic                             done_o,
  output state_t                           dbg_state_o
);

  localparam int CW = $clog2(MAX_FIELDS + 1);
  localparam int PW = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q, done_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [15:0]              pos_q, pos_d;
  logic [15:0]              body_len_q, body_len_d;
  logic [7:0]               csum_q, csum_d;
  fld_t                     fld_q [MAX_FIELDS];
  fld_t                     fld_d [MAX_FIELDS];
  logic [8*VALUE_BYTES-1:0] val_q [MAX_FIELDS];
  logic [8*VALUE_BYTES-1:0] val_d [MAX_FIELDS];

  logic        conv_start, conv_done, conv_busy;
  logic [15:0] conv_bin;
  logic [19:0] conv_bcd;
  logic [63:0] begin_str;
  fld_t        cur;
  logic [8*VALUE_BYTES-1:0] cur_val;
  logic [7:0]  byte_w;
  logic        last_w, xfer;
  logic        nxt_found, first_found;
  logic [PW-1:0] nxt_idx, first_idx;
  logic [15:0] wr_vlen;

  assign begin_str = BEGIN_STR;
  assign cur       = fld_q[ptr_q];
  assign cur_val   = val_q[ptr_q];

  // LCONV and CCONV share one converter; the operand follows the state.
  assign conv_bin = (state_q == ST_CCONV) ? {8'd0, csum_q} : body_len_q;

  fix_bin2dec u_bin2dec (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .bcd_o   (conv_bcd),
    .done_o  (conv_done),
    .busy_o  (conv_busy)
  );

  // Skipped entries cost no cycles: the next emitted entry is found combinationally.
  always_comb begin
    nxt_found   = 1'b0;
    nxt_idx     = '0;
    first_found = 1'b0;
    first_idx   = '0;
    for (int i = MAX_FIELDS - 1; i >= 0; i--) begin
      if (fld_q[i].vld) begin
        first_found = 1'b1;
        first_idx   = PW'(i);
        if (i > int'(ptr_q)) begin
          nxt_found = 1'b1;
          nxt_idx   = PW'(i);
        end
      end
    end
  end

  // Byte selection for the current emitting state and position.
  always_comb begin
    int p, tl, vl, nd;
    p      = int'(pos_q);
    tl     = int'(cur.tag_len);
    vl     = int'(cur.val_len);
    nd     = int'(bcd_digits(conv_bcd));
    byte_w = 8'h00;
    last_w = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (p == 0)                  byte_w = TAG_BEGIN_STRING;
        else if (p == 1)             byte_w = CH_EQ;
        else if (p < BEGIN_LEN + 2)  byte_w = begin_str[8*(p-2) +: 8];
        else begin
          byte_w = CH_SOH;
          last_w = 1'b1;
        end
      end
      ST_LEN: begin
        if (p == 0)           byte_w = TAG_BODY_LENGTH;
        else if (p == 1)      byte_w = CH_EQ;
        else if (p < 2 + nd)  byte_w = {4'h3, conv_bcd[4*(nd+1-p) +: 4]};
        else begin
          byte_w = CH_SOH;
          last_w = 1'b1;
        end
      end
      ST_BODY: begin
        if (p < tl)             byte_w = cur.tag[8*p +: 8];
        else if (p == tl)       byte_w = CH_EQ;
        else if (p <= tl + vl)  byte_w = cur_val[8*(p-tl-1) +: 8];
        else begin
          byte_w = CH_SOH;
          last_w = 1'b1;
        end
      end
      ST_TRL: begin
        case (p)
          0:       byte_w = TAG_CHECKSUM[7:0];
          1:       byte_w = TAG_CHECKSUM[15:8];
          2:       byte_w = CH_EQ;
          3:       byte_w = {4'h3, conv_bcd[11:8]};
          4:       byte_w = {4'h3, conv_bcd[7:4]};
          5:       byte_w = {4'h3, conv_bcd[3:0]};
          default: begin
            byte_w = CH_SOH;
            last_w = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign byte_valid_o = (state_q == ST_HDR) || (state_q == ST_LEN) ||
                        (state_q == ST_BODY) || (state_q == ST_TRL);
  assign byte_o       = byte_valid_o ? byte_w : 8'h00;
  assign xfer         = byte_valid_o && byte_ready_i;

  assign wr_vlen = (int'(fld_val_len_i) > VALUE_BYTES) ? 16'(VALUE_BYTES) : 16'(fld_val_len_i);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    ptr_d      = ptr_q;
    pos_d      = pos_q;
    body_len_d = body_len_q;
    csum_d     = csum_q;
    fld_d      = fld_q;
    val_d      = val_q;
    conv_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The write is handled before start so a same-cycle field joins the message.
        if (fld_wr_i) begin
          if (cnt_q != CW'(MAX_FIELDS)) begin
            fld_d[PW'(cnt_q)] = '{tag:     fld_tag_i,
                                  tag_len: fld_tag_len_i,
                                  val_len: wr_vlen,
                                  vld:     (fld_tag_len_i != 3'd0) && (fld_tag_len_i <= 3'd4)};
            val_d[PW'(cnt_q)] = fld_val_i;
            cnt_d = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (start_i) begin
          ovf_d      = 1'b0;
          body_len_d = '0;
          csum_d     = '0;
          ptr_d      = '0;
          pos_d      = '0;
          state_d    = (cnt_d == '0) ? ST_LCONV : ST_CALC;
        end
      end

      ST_CALC: begin
        if (cur.vld) body_len_d = body_len_q + 16'(cur.tag_len) + cur.val_len + 16'd2;
        ptr_d = ptr_q + PW'(1);
        if (int'(ptr_q) == int'(cnt_q) - 1) state_d = ST_LCONV;
      end

      ST_LCONV, ST_CCONV: begin
        conv_start = !conv_busy && !conv_done;
        if (conv_done) begin
          pos_d   = '0;
          state_d = (state_q == ST_LCONV) ? ST_HDR : ST_TRL;
        end
      end

      ST_HDR, ST_LEN, ST_BODY: begin
        if (xfer) begin
          csum_d = csum_q + byte_w;
          pos_d  = pos_q + 16'd1;
          if (last_w) begin
            pos_d = '0;
            if (state_q == ST_HDR) begin
              state_d = ST_LEN;
            end else if (state_q == ST_LEN ? first_found : nxt_found) begin
              ptr_d   = (state_q == ST_LEN) ? first_idx : nxt_idx;
              state_d = ST_BODY;
            end else begin
              state_d = ST_CCONV;
            end
          end
        end
      end

      ST_TRL: begin
        if (xfer) begin
          pos_d = pos_q + 16'd1;
          if (last_w) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
            for (int i = 0; i < MAX_FIELDS; i++) fld_d[i].vld = 1'b0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      ptr_q      <= '0;
      pos_q      <= '0;
      body_len_q <= '0;
      csum_q     <= '0;
      fld_q      <= '{default: '0};
      val_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      ptr_q      <= ptr_d;
      pos_q      <= pos_d;
      body_len_q <= body_len_d;
      csum_q     <= csum_d;
      fld_q      <= fld_d;
      val_q      <= val_d;
    end
  end

  assign fld_full_o  = (cnt_q == CW'(MAX_FIELDS));
  assign fld_ovf_o   = ovf_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fix_msg_builder.sv
// Bench for fix_msg_builder: a FIX-level model builds each expected message as
// a byte queue; a monitor pops and compares every accepted output byte.
module tb_fix_msg_builder;
  import fix_pkg::*;

  localparam int VB = 32;
  localparam int MF = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fld_wr_i;
  logic [31:0]   fld_tag_i;
  logic [2:0]    fld_tag_len_i;
  logic [8*VB-1:0] fld_val_i;
  logic [5:0]    fld_val_len_i;
  logic          fld_full_o, fld_ovf_o;
  logic          start_i, busy_o;
  logic [7:0]    byte_o;
  logic          byte_valid_o, byte_ready_i, done_o;
  state_t        dbg_state;

  fix_msg_builder dut (
    .clk           (clk),
    .rst           (rst),
    .fld_wr_i      (fld_wr_i),
    .fld_tag_i     (fld_tag_i),
    .fld_tag_len_i (fld_tag_len_i),
    .fld_val_i     (fld_val_i),
    .fld_val_len_i (fld_val_len_i),
    .fld_full_o    (fld_full_o),
    .fld_ovf_o     (fld_ovf_o),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .byte_o        (byte_o),
    .byte_valid_o  (byte_valid_o),
    .byte_ready_i  (byte_ready_i),
    .done_o        (done_o),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state and scoreboard ----------------
  typedef struct {
    logic [31:0]   tag;
    int            tl;
    logic [8*VB-1:0] val;
    int            vl;
  } mfld_t;

  mfld_t      m_q[$];
  bit         m_ovf;
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         n_acc  = 0;
  bit         ready_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the buffer: capacity MF, overflow flag on a dropped write.
  function automatic void model_write(input mfld_t f);
    if (m_q.size() < MF) m_q.push_back(f);
    else m_ovf = 1'b1;
  endfunction

  function automatic void push_str(inout logic [7:0] q[$], input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  // Expected message from the FIX framing rules.
  function automatic void push_expected();
    logic [7:0] body[$];
    logic [7:0] msg[$];
    int sum;
    foreach (m_q[k]) begin
      if (m_q[k].tl >= 1 && m_q[k].tl <= 4) begin
        int vl;
        vl = (m_q[k].vl > VB) ? VB : m_q[k].vl;
        for (int i = 0; i < m_q[k].tl; i++) body.push_back(m_q[k].tag[8*i +: 8]);
        body.push_back("=");
        for (int i = 0; i < vl; i++) body.push_back(m_q[k].val[8*i +: 8]);
        body.push_back(8'h01);
      end
    end
    push_str(msg, "8=FIX.4.4");
    msg.push_back(8'h01);
    push_str(msg, $sformatf("9=%0d", body.size()));
    msg.push_back(8'h01);
    foreach (body[i]) msg.push_back(body[i]);
    sum = 0;
    foreach (msg[i]) sum += int'(msg[i]);
    push_str(msg, $sformatf("10=%03d", sum % 256));
    msg.push_back(8'h01);
    foreach (msg[i]) exp_q.push_back(msg[i]);
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic       prev_v, prev_r;
    logic [7:0] prev_b;
    logic [7:0] e;
    prev_v = 1'b0; prev_r = 1'b0; prev_b = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          check("stall_valid_held", {31'd0, byte_valid_o}, 32'd1);
          check("stall_byte_held", {24'd0, byte_o}, {24'd0, prev_b});
        end
        if (byte_valid_o && byte_ready_i) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'd0, byte_o}, 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            check("stream_byte", {24'd0, byte_o}, {24'd0, e});
          end
        end
        prev_v = byte_valid_o;
        prev_r = byte_ready_i;
        prev_b = byte_o;
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    byte_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      byte_ready_i = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic mfld_t rand_field(input int tl, input int vl);
    mfld_t f;
    f.tag = '0;
    for (int i = 0; i < 4; i++) f.tag[8*i +: 8] = 8'h30 + 8'($urandom_range(1, 9));
    for (int i = 0; i < VB; i++) f.val[8*i +: 8] = 8'h41 + 8'($urandom_range(0, 25));
    f.tl = tl;
    f.vl = vl;
    return f;
  endfunction

  function automatic mfld_t fixed_field(input logic [31:0] tag, input int tl,
                                        input logic [15:0] val, input int vl);
    mfld_t f;
    f.tag = tag;
    f.tl  = tl;
    f.val = '0;
    f.val[15:0] = val;
    f.vl  = vl;
    return f;
  endfunction

  task automatic drive_field(input mfld_t f);
    fld_tag_i     = f.tag;
    fld_tag_len_i = 3'(f.tl);
    fld_val_i     = f.val;
    fld_val_len_i = 6'(f.vl);
    fld_wr_i      = 1'b1;
  endtask

  task automatic write_field(input mfld_t f);
    @(posedge clk); #1;
    drive_field(f);
    @(posedge clk); #1;
    fld_wr_i = 1'b0;
    model_write(f);
    check("fld_full", {31'd0, fld_full_o}, {31'd0, m_q.size() == MF});
    check("fld_ovf", {31'd0, fld_ovf_o}, {31'd0, m_ovf});
  endtask

  task automatic start_msg(input bit wr_with_start);
    @(posedge clk); #1;
    start_i = 1'b1;
    if (wr_with_start) begin
      mfld_t f;
      f = rand_field($urandom_range(1, 4), $urandom_range(0, VB));
      drive_field(f);
      model_write(f);
    end
    m_ovf = 1'b0;
    push_expected();
    n_acc = 0;
    @(posedge clk); #1;
    start_i  = 1'b0;
    fld_wr_i = 1'b0;
  endtask

  task automatic run_msg(input bit rand_ready, input bit wr_with_start, input bit wr_while_busy);
    int lat;
    bit seen;
    ready_rand = rand_ready;
    start_msg(wr_with_start);
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    check("ovf_cleared", {31'd0, fld_ovf_o}, 32'd0);
    lat = -1;
    for (int j = 0; j < 200; j++) begin
      if (byte_valid_o) begin
        lat = j;
        break;
      end
      if (j == 3 && wr_while_busy) drive_field(rand_field(2, 3));
      else fld_wr_i = 1'b0;
      @(posedge clk); #1;
    end
    fld_wr_i = 1'b0;
    check("first_valid_latency", 32'(lat), 32'(m_q.size() + 17));
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("busy_low_at_done", {31'd0, busy_o}, 32'd0);
    check("all_bytes_sent", 32'(exp_q.size()), 32'd0);
    check("buffer_empty_after", {31'd0, fld_full_o}, 32'd0);
    @(negedge clk);
    check("done_one_pulse", {31'd0, done_o}, 32'd0);
    exp_q.delete();
    m_q.delete();
    ready_rand = 1'b0;
  endtask

  task automatic write_fixed_pair();
    write_field(fixed_field(32'h0000_3533, 2, 16'h0030, 1));  // 35=0
    write_field(fixed_field(32'h0000_3934, 2, 16'h4241, 2));  // 49=AB
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit reached;
    rst = 1'b1;
    fld_wr_i = 1'b0; fld_tag_i = '0; fld_tag_len_i = '0;
    fld_val_i = '0; fld_val_len_i = '0; start_i = 1'b0;
    m_ovf = 1'b0;
    #12;
    check("rst_valid", {31'd0, byte_valid_o}, 32'd0);
    check("rst_byte", {24'd0, byte_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_full", {31'd0, fld_full_o}, 32'd0);
    check("rst_ovf", {31'd0, fld_ovf_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two fixed fields, ready always high.
    write_fixed_pair();
    run_msg(1'b0, 1'b0, 1'b0);

    // Empty buffer.
    run_msg(1'b0, 1'b0, 1'b0);

    // Same two fields with random backpressure.
    write_fixed_pair();
    run_msg(1'b1, 1'b0, 1'b0);

    // Overflow: one write beyond capacity is dropped.
    for (int i = 0; i < MF + 1; i++) write_field(rand_field($urandom_range(1, 4), $urandom_range(0, VB)));
    run_msg(1'b1, 1'b0, 1'b1);

    // Clamped value length, skipped tag lengths, empty value.
    write_field(rand_field(2, VB + 3));
    write_field(rand_field(0, 5));
    write_field(rand_field(5, 3));
    write_field(rand_field(3, 0));
    write_field(rand_field(4, VB));
    run_msg(1'b1, 1'b0, 1'b0);

    // Random messages.
    for (int it = 0; it < 5; it++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) write_field(rand_field($urandom_range(0, 5), $urandom_range(0, VB + 3)));
      run_msg(1'($urandom_range(0, 1)), 1'(it % 2), 1'b1);
    end

    // Reset in the middle of the body.
    write_fixed_pair();
    ready_rand = 1'b0;
    start_msg(1'b0);
    reached = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      if (n_acc >= 18) begin
        reached = 1'b1;
        break;
      end
    end
    check("reached_body", {31'd0, reached}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, byte_valid_o}, 32'd0);
    check("midrst_byte", {24'd0, byte_o}, 32'd0);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    exp_q.delete();
    m_q.delete();
    m_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("no_done_after_rst", {31'd0, done_o}, 32'd0);
    check("buffer_empty_after_rst", {31'd0, fld_full_o}, 32'd0);
    write_fixed_pair();
    run_msg(1'b1, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
